// File: rtl/jtframe_pocket_i2s.sv
// jtframe_pocket_i2s: serialises held stereo samples into a 64-bit-per-frame I2S stream for the Pocket DAC
module jtframe_pocket_i2s #(
  parameter logic SIGNED_SND = 1'b0,
  parameter int   MCLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snd_left,
  input  logic [15:0] snd_right,
  input  logic        snd_sample,
  input  logic        mute,
  output logic        audio_sclk,
  output logic        audio_lrck,
  output logic        audio_dac
);
  localparam int W = $clog2(MCLK_DIV);
  localparam logic [15:0] FLIP = {~SIGNED_SND, 15'd0};
  logic [W-1:0] div, div_nx;
  logic [5:0]   bitcnt, bc_nx;
  logic [15:0]  held_l, held_r, fl, fr;
  logic         f, bit_nx;
  always_comb begin
    f      = div == W'(MCLK_DIV - 1);
    div_nx = f ? '0 : div + 1'b1;
    bc_nx  = bitcnt + 6'd1;
    // one-bit I2S delay: slot n carries bit 16-n of its word
    bit_nx = bc_nx inside {[6'd1:6'd16]}  ? fl[4'(6'd16 - bc_nx)] :
             bc_nx inside {[6'd33:6'd48]} ? fr[4'(6'd48 - bc_nx)] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      bitcnt     <= '0;
      audio_sclk <= 1'b0;
      audio_lrck <= 1'b0;
      audio_dac  <= 1'b0;
      held_l     <= '0;
      held_r     <= '0;
      fl         <= '0;
      fr         <= '0;
    end else begin
      div        <= div_nx;
      audio_sclk <= div_nx >= W'(MCLK_DIV / 2);
      if (snd_sample) begin
        held_l <= snd_left ^ FLIP;
        held_r <= snd_right ^ FLIP;
      end
      if (f) begin
        bitcnt     <= bc_nx;
        audio_lrck <= bc_nx[5];
        audio_dac  <= bit_nx;
        if (bc_nx == 6'd0) begin
          fl <= mute ? '0 : held_l;
          fr <= mute ? '0 : held_r;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtframe_pocket_i2s.sv
// tb_jtframe_pocket_i2s: randomized and directed checks of signed and offset-binary I2S outputs against a frame-level model
module tb_jtframe_pocket_i2s;
  localparam int D = 4;
  logic clk = 0, rst = 1, snd_sample = 0, mute = 0;
  logic [15:0] snd_left = 0, snd_right = 0;
  logic [1:0] sclk, lrck, dac;
  int total = 0, bad = 0;
  int k = 0;
  bit chk_en = 0;
  logic [15:0] held_l[2], held_r[2], fl_m[2], fr_m[2], cap_l[2], cap_r[2];
  localparam logic [15:0] MASK[2] = '{16'h0000, 16'h8000};

  always #5 clk = ~clk;

  jtframe_pocket_i2s #(.SIGNED_SND(1'b1), .MCLK_DIV(D)) u_s (
    .clk(clk), .rst(rst), .snd_left(snd_left), .snd_right(snd_right),
    .snd_sample(snd_sample), .mute(mute),
    .audio_sclk(sclk[0]), .audio_lrck(lrck[0]), .audio_dac(dac[0]));
  jtframe_pocket_i2s #(.SIGNED_SND(1'b0), .MCLK_DIV(D)) u_u (
    .clk(clk), .rst(rst), .snd_left(snd_left), .snd_right(snd_right),
    .snd_sample(snd_sample), .mute(mute),
    .audio_sclk(sclk[1]), .audio_lrck(lrck[1]), .audio_dac(dac[1]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", nm, act, exp, k);
    end
  endtask

  // model: k = clk edges since reset, frame words latched at every 64th sclk period
  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      for (int i = 0; i < 2; i++) begin
        held_l[i] = 0; held_r[i] = 0; fl_m[i] = 0; fr_m[i] = 0;
      end
    end else begin
      k++;
      if (k % D == 0 && (k / D) % 64 == 0)
        for (int i = 0; i < 2; i++) begin
          fl_m[i] = mute ? 16'h0 : held_l[i];
          fr_m[i] = mute ? 16'h0 : held_r[i];
        end
      if (snd_sample)
        for (int i = 0; i < 2; i++) begin
          held_l[i] = snd_left ^ MASK[i];
          held_r[i] = snd_right ^ MASK[i];
        end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      logic es, el, ed;
      n  = (k / D) % 64;
      es = (k % D) >= D / 2;
      el = n >= 32;
      for (int i = 0; i < 2; i++) begin
        ed = (n >= 1 && n <= 16) ? fl_m[i][16 - n] : (n >= 33 && n <= 48) ? fr_m[i][48 - n] : 1'b0;
        chk($sformatf("sclk%0d", i), {15'd0, sclk[i]}, {15'd0, es});
        chk($sformatf("lrck%0d", i), {15'd0, lrck[i]}, {15'd0, el});
        chk($sformatf("dac%0d", i), {15'd0, dac[i]}, {15'd0, ed});
        if (k > 0 && k % D == 0) begin
          if (n >= 1 && n <= 16) cap_l[i] = {cap_l[i][14:0], dac[i]};
          if (n >= 33 && n <= 48) cap_r[i] = {cap_r[i][14:0], dac[i]};
        end
      end
    end
  end

  task automatic wait_n(input int n);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(k > 0 && k % D == 0 && (k / D) % 64 == n) && b < 20000);
    if (b >= 20000) begin
      bad++;
      $display("FAIL wait_n%0d: timeout", n);
    end
    #2;
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk); #1;
    snd_left = l; snd_right = r; snd_sample = 1;
    @(negedge clk); #1;
    snd_sample = 0;
  endtask

  task automatic words(input string nm, input logic [15:0] sl, input logic [15:0] sr,
                       input logic [15:0] ul, input logic [15:0] ur);
    chk({nm, "_sl"}, cap_l[0], sl);
    chk({nm, "_sr"}, cap_r[0], sr);
    chk({nm, "_ul"}, cap_l[1], ul);
    chk({nm, "_ur"}, cap_r[1], ur);
  endtask

  initial begin
    int ones_l, ones_s, ones_d, b;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #1 rst = 0;
    // idle run: 8 full frames of 256 clk, 50% duty, silent data
    ones_l = 0; ones_s = 0; ones_d = 0;
    repeat (2048) begin
      @(negedge clk); #2;
      ones_l += lrck[0]; ones_s += sclk[0]; ones_d += dac[0] + dac[1];
    end
    chk("idle_lrck_ones", 16'(ones_l), 16'd1024);
    chk("idle_sclk_ones", 16'(ones_s), 16'd1024);
    chk("idle_dac_ones", 16'(ones_d), 16'd0);
    strobe(16'hA5C3, 16'h8001);
    wait_n(0); wait_n(49);
    words("pat1", 16'hA5C3, 16'h8001, 16'h25C3, 16'h0001);
    strobe(16'h0000, 16'hFFFF);
    wait_n(0); wait_n(49);
    words("pat2", 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF);
    // strobe lands on the latch edge itself
    b = 0;
    do begin @(negedge clk); b++; end
    while (!(k % D == D - 1 && (k / D) % 64 == 63) && b < 20000);
    #1 snd_left = 16'h1234; snd_right = 16'h1234; snd_sample = 1;
    @(negedge clk); #1 snd_sample = 0;
    wait_n(49);
    words("coinc_old", 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF);
    wait_n(49);
    words("coinc_new", 16'h1234, 16'h1234, 16'h9234, 16'h9234);
    strobe(16'hFFFF, 16'hFFFF);
    wait_n(20);
    mute = 1;
    wait_n(49);
    words("mute_inflight", 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF);
    wait_n(49);
    words("mute_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    mute = 0;
    wait_n(49);
    words("unmute", 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF);
    // reset mid-frame
    wait_n(20);
    rst = 1;
    @(negedge clk); #2;
    chk("rst_outs", {10'd0, sclk, lrck, dac}, 16'd0);
    rst = 0;
    b = 0;
    do begin @(negedge clk); b++; end while (k != 127 && b < 1000);
    #2 chk("rst_lrck127", {15'd0, lrck[0]}, 16'd0);
    @(negedge clk); #2;
    chk("rst_lrck128", {15'd0, lrck[0]}, 16'd1);
    wait_n(49);
    words("rst_frame", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    // random strobes and mute changes against the model
    repeat (6000) begin
      @(negedge clk); #1;
      snd_sample = ($urandom_range(0, 19) == 0);
      if (snd_sample) begin
        snd_left = 16'($urandom); snd_right = 16'($urandom);
      end
      if ($urandom_range(0, 499) == 0) mute = ~mute;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
